// File: rtl/warp_pkg.sv
// Shared types for the warp_hart dual-issue RV64I ALU core: opcodes, lanes,
// ALU operations and the decoded micro-op carried from Decode to Issue.
package warp_pkg;

    localparam int XLEN = 64;
    localparam int VA_W = 39;

    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'd0;
    localparam logic [2:0] F3_SLL  = 3'd1;
    localparam logic [2:0] F3_SLT  = 3'd2;
    localparam logic [2:0] F3_SLTU = 3'd3;
    localparam logic [2:0] F3_XOR  = 3'd4;
    localparam logic [2:0] F3_SR   = 3'd5;
    localparam logic [2:0] F3_OR   = 3'd6;
    localparam logic [2:0] F3_AND  = 3'd7;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic {LANE_A, LANE_B} lane_e;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_SRL, ALU_SRA, ALU_XOR, ALU_OR, ALU_AND
    } aluop_e;

    typedef struct packed {
        logic            valid;
        lane_e           lane;
        logic [4:0]      rd;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic            use_imm;
        logic [XLEN-1:0] imm;
        aluop_e          aluop;
    } uop_t;

    function automatic lane_e lane_of(input aluop_e op);
        return (op == ALU_XOR || op == ALU_OR || op == ALU_AND) ? LANE_B : LANE_A;
    endfunction

endpackage

// File: rtl/warp_regfile.sv
// 32x64 integer register file: four asynchronous read ports, two write ports
// where port 1 (the younger instruction) wins on a same-register collision.
module warp_regfile
    import warp_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [4:0]      ra0,
    input  logic [4:0]      ra1,
    input  logic [4:0]      ra2,
    input  logic [4:0]      ra3,
    output logic [XLEN-1:0] rdata0,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    output logic [XLEN-1:0] rdata3,
    input  logic            we0,
    input  logic [4:0]      wa0,
    input  logic [XLEN-1:0] wd0,
    input  logic            we1,
    input  logic [4:0]      wa1,
    input  logic [XLEN-1:0] wd1
);

    logic [XLEN-1:0] file [32];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) file[i] <= '0;
        end else begin
            for (int i = 1; i < 32; i++) begin
                if (we1 && wa1 == 5'(i))      file[i] <= wd1;
                else if (we0 && wa0 == 5'(i)) file[i] <= wd0;
            end
        end
    end

    assign rdata0 = file[ra0];
    assign rdata1 = file[ra1];
    assign rdata2 = file[ra2];
    assign rdata3 = file[ra3];

endmodule

// File: rtl/warp_hart.sv
// In-order dual-issue RV64I ALU hart: Fetch, Decode, Issue, Execute, Writeback
// with a busy-bit scoreboard, no forwarding, and an arith lane plus a logic lane.
//
// state    | meaning
// ST_INIT  | one idle cycle after reset release, no fetch request
// ST_FETCH | request bundles at pc whenever the fetch buffer can take one
module warp_hart
    import warp_pkg::*;
#(
    parameter logic [VA_W-1:0] RESET_ADDR = 39'h4000000000
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    output logic            o_imem_ren,
    output logic [VA_W-1:0] o_imem_raddr,
    input  logic            i_imem_valid,
    input  logic [63:0]     i_imem_rdata
);

    typedef enum logic {ST_INIT, ST_FETCH} state_e;

    typedef struct packed {
        logic            valid;
        logic [4:0]      rd;
        aluop_e          op;
        logic [XLEN-1:0] x;
        logic [XLEN-1:0] y;
    } ex_t;

    state_e          state_q, state_d;
    logic [VA_W-1:0] pc_q;
    logic            fb_valid_q;
    logic [63:0]     fb_data_q;
    uop_t            d0_q, d1_q;
    ex_t             ex_a_q, ex_b_q, ex_a_d, ex_b_d;
    logic            young_b_q;
    logic [31:0]     busy_q, busy_set, busy_clr;
    logic [XLEN-1:0] rdata0, rdata1, rdata2, rdata3, res_a, res_b;
    logic            iss0, iss1, raw10, d_drain, fb_adv, cap, we_a, we_b;

    function automatic uop_t decode(input logic [31:0] ins);
        uop_t u;
        u         = '0;
        u.rd      = ins[11:7];
        u.rs1     = ins[19:15];
        u.rs2     = ins[24:20];
        u.imm     = {{52{ins[31]}}, ins[31:20]};
        u.aluop   = ALU_ADD;
        case (ins[6:0])
            OPC_OP_IMM: begin
                u.valid   = 1'b1;
                u.use_imm = 1'b1;
                u.rs2     = '0;
                case (ins[14:12])
                    F3_SLT:  u.aluop = ALU_SLT;
                    F3_SLTU: u.aluop = ALU_SLTU;
                    F3_XOR:  u.aluop = ALU_XOR;
                    F3_OR:   u.aluop = ALU_OR;
                    F3_AND:  u.aluop = ALU_AND;
                    F3_SLL: begin
                        u.aluop = ALU_SLL;
                        u.valid = (ins[31:26] == 6'b0);
                    end
                    F3_SR: begin
                        u.aluop = ins[30] ? ALU_SRA : ALU_SRL;
                        u.valid = ({ins[31], ins[29:26]} == 5'b0);
                    end
                    default: u.aluop = ALU_ADD;
                endcase
            end
            OPC_OP: begin
                u.valid = 1'b1;
                case ({ins[31:25], ins[14:12]})
                    {F7_BASE, F3_ADD}:  u.aluop = ALU_ADD;
                    {F7_ALT,  F3_ADD}:  u.aluop = ALU_SUB;
                    {F7_BASE, F3_SLL}:  u.aluop = ALU_SLL;
                    {F7_BASE, F3_SLT}:  u.aluop = ALU_SLT;
                    {F7_BASE, F3_SLTU}: u.aluop = ALU_SLTU;
                    {F7_BASE, F3_XOR}:  u.aluop = ALU_XOR;
                    {F7_BASE, F3_SR}:   u.aluop = ALU_SRL;
                    {F7_ALT,  F3_SR}:   u.aluop = ALU_SRA;
                    {F7_BASE, F3_OR}:   u.aluop = ALU_OR;
                    {F7_BASE, F3_AND}:  u.aluop = ALU_AND;
                    default:            u.valid = 1'b0;
                endcase
            end
            OPC_LUI: begin
                // LUI becomes x0 + imm so it shares the adder in lane A.
                u.valid   = 1'b1;
                u.use_imm = 1'b1;
                u.rs1     = '0;
                u.rs2     = '0;
                u.imm     = {{32{ins[31]}}, ins[31:12], 12'b0};
            end
            default: u.valid = 1'b0;
        endcase
        u.lane = lane_of(u.aluop);
        return u;
    endfunction

    function automatic ex_t mk_ex(input uop_t u, input logic [XLEN-1:0] r1,
                                  input logic [XLEN-1:0] r2);
        ex_t e;
        e.valid = 1'b1;
        e.rd    = u.rd;
        e.op    = u.aluop;
        e.x     = r1;
        e.y     = u.use_imm ? u.imm : r2;
        return e;
    endfunction

    always_comb begin
        state_d    = state_q;
        o_imem_ren = 1'b0;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: o_imem_ren = !fb_valid_q || fb_adv;
            default:  state_d = ST_INIT;
        endcase
    end

    assign cap          = o_imem_ren && i_imem_valid;
    assign o_imem_raddr = pc_q;

    // Unused source fields are x0, which is never busy, so no per-op masking.
    always_comb begin
        raw10   = (d0_q.rd != 5'd0) && (d1_q.rs1 == d0_q.rd || d1_q.rs2 == d0_q.rd);
        iss0    = d0_q.valid && !(busy_q[d0_q.rs1] || busy_q[d0_q.rs2]);
        iss1    = d1_q.valid && !(busy_q[d1_q.rs1] || busy_q[d1_q.rs2])
                  && (!d0_q.valid || (iss0 && d0_q.lane != d1_q.lane && !raw10));
        d_drain = (!d0_q.valid || iss0) && (!d1_q.valid || iss1);
        fb_adv  = fb_valid_q && d_drain;
    end

    always_comb begin
        ex_a_d   = '0;
        ex_b_d   = '0;
        busy_set = '0;
        busy_clr = '0;
        if (iss0) begin
            if (d0_q.lane == LANE_A) ex_a_d = mk_ex(d0_q, rdata0, rdata1);
            else                     ex_b_d = mk_ex(d0_q, rdata0, rdata1);
            if (d0_q.rd != 5'd0) busy_set[d0_q.rd] = 1'b1;
        end
        if (iss1) begin
            if (d1_q.lane == LANE_A) ex_a_d = mk_ex(d1_q, rdata2, rdata3);
            else                     ex_b_d = mk_ex(d1_q, rdata2, rdata3);
            if (d1_q.rd != 5'd0) busy_set[d1_q.rd] = 1'b1;
        end
        if (ex_a_q.valid) busy_clr[ex_a_q.rd] = 1'b1;
        if (ex_b_q.valid) busy_clr[ex_b_q.rd] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_INIT;
            pc_q       <= {RESET_ADDR[VA_W-1:3], 3'b000};
            fb_valid_q <= 1'b0;
            fb_data_q  <= '0;
            d0_q       <= '0;
            d1_q       <= '0;
            ex_a_q     <= '0;
            ex_b_q     <= '0;
            young_b_q  <= 1'b0;
            busy_q     <= '0;
        end else begin
            state_q    <= state_d;
            fb_valid_q <= cap || (fb_valid_q && !fb_adv);
            if (cap) begin
                fb_data_q <= i_imem_rdata;
                pc_q      <= pc_q + VA_W'(8);
            end
            if (fb_adv) begin
                d0_q <= decode(fb_data_q[31:0]);
                d1_q <= decode(fb_data_q[63:32]);
            end else begin
                if (iss0) d0_q.valid <= 1'b0;
                if (iss1) d1_q.valid <= 1'b0;
            end
            ex_a_q    <= ex_a_d;
            ex_b_q    <= ex_b_d;
            young_b_q <= iss0 && iss1 && d1_q.lane == LANE_B;
            // A new issue to a register retiring this same edge must stay busy.
            busy_q    <= (busy_q & ~busy_clr) | busy_set;
        end
    end

    always_comb begin
        res_a = '0;
        case (ex_a_q.op)
            ALU_ADD:  res_a = ex_a_q.x + ex_a_q.y;
            ALU_SUB:  res_a = ex_a_q.x - ex_a_q.y;
            ALU_SLL:  res_a = ex_a_q.x << ex_a_q.y[5:0];
            ALU_SLT:  res_a = {63'b0, $signed(ex_a_q.x) < $signed(ex_a_q.y)};
            ALU_SLTU: res_a = {63'b0, ex_a_q.x < ex_a_q.y};
            ALU_SRL:  res_a = ex_a_q.x >> ex_a_q.y[5:0];
            ALU_SRA:  res_a = $signed(ex_a_q.x) >>> ex_a_q.y[5:0];
            default:  res_a = '0;
        endcase
    end

    always_comb begin
        res_b = '0;
        case (ex_b_q.op)
            ALU_XOR: res_b = ex_b_q.x ^ ex_b_q.y;
            ALU_OR:  res_b = ex_b_q.x | ex_b_q.y;
            ALU_AND: res_b = ex_b_q.x & ex_b_q.y;
            default: res_b = '0;
        endcase
    end

    assign we_a = ex_a_q.valid && ex_a_q.rd != 5'd0;
    assign we_b = ex_b_q.valid && ex_b_q.rd != 5'd0;

    // Port 1 carries the younger instruction of a pair so it wins on equal rd.
    warp_regfile xrf (
        .clk    (i_clk),
        .rst_n  (i_rst_n),
        .ra0    (d0_q.rs1),
        .ra1    (d0_q.rs2),
        .ra2    (d1_q.rs1),
        .ra3    (d1_q.rs2),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .rdata2 (rdata2),
        .rdata3 (rdata3),
        .we0    (young_b_q ? we_a : we_b),
        .wa0    (young_b_q ? ex_a_q.rd : ex_b_q.rd),
        .wd0    (young_b_q ? res_a : res_b),
        .we1    (young_b_q ? we_b : we_a),
        .wa1    (young_b_q ? ex_b_q.rd : ex_a_q.rd),
        .wd1    (young_b_q ? res_b : res_a)
    );

endmodule

// File: tb/tb_warp_hart.sv
// Scoreboard bench for warp_hart: an architectural model queues expected
// register writes; a monitor on the register-file write ports checks them.
module tb_warp_hart;

    localparam logic [38:0] RST_A = 39'h4000000000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren;
    logic [38:0] raddr;
    logic        ivalid;
    logic [63:0] idata;

    warp_hart dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .o_imem_ren   (ren),
        .o_imem_raddr (raddr),
        .i_imem_valid (ivalid),
        .i_imem_rdata (idata)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          wcyc [32];
    logic [63:0] xm [32];
    logic [38:0] pc_m;
    logic [68:0] exp_q [$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, expv);
    endtask

    function automatic logic [31:0] enc_i(input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, f3, rd, 7'h13};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {f7, rs2, rs1, f3, rd, 7'h33};
    endfunction

    // Architectural execution of one instruction, one at a time in program order.
    task automatic model_exec(input logic [31:0] ins);
        logic [4:0]  rd;
        logic [63:0] a, b, r;
        logic [5:0]  sh;
        logic        ok;
        rd = ins[11:7];
        a  = xm[ins[19:15]];
        r  = '0;
        ok = 1'b1;
        case (ins[6:0])
            7'h13: begin
                b  = {{52{ins[31]}}, ins[31:20]};
                sh = ins[25:20];
                case (ins[14:12])
                    3'd0: r = a + b;
                    3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                    3'd3: r = (a < b) ? 64'd1 : 64'd0;
                    3'd4: r = a ^ b;
                    3'd6: r = a | b;
                    3'd7: r = a & b;
                    3'd1: if (ins[31:26] == 6'h00) r = a << sh; else ok = 1'b0;
                    default: begin
                        if (ins[31:26] == 6'h00)      r = a >> sh;
                        else if (ins[31:26] == 6'h10) r = $signed(a) >>> sh;
                        else                          ok = 1'b0;
                    end
                endcase
            end
            7'h33: begin
                b  = xm[ins[24:20]];
                sh = b[5:0];
                if (ins[31:25] == 7'h00) begin
                    case (ins[14:12])
                        3'd0: r = a + b;
                        3'd1: r = a << sh;
                        3'd2: r = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                        3'd3: r = (a < b) ? 64'd1 : 64'd0;
                        3'd4: r = a ^ b;
                        3'd5: r = a >> sh;
                        3'd6: r = a | b;
                        default: r = a & b;
                    endcase
                end else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd0) r = a - b;
                else if (ins[31:25] == 7'h20 && ins[14:12] == 3'd5)     r = $signed(a) >>> sh;
                else ok = 1'b0;
            end
            7'h37: r = {{32{ins[31]}}, ins[31:12], 12'h000};
            default: ok = 1'b0;
        endcase
        if (ok && rd != 5'd0) begin
            xm[rd] = r;
            exp_q.push_back({rd, r});
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) xm[i] = '0;
        pc_m = RST_A;
        exp_q.delete();
    endtask

    task automatic mon_write(input logic [4:0] a, input logic [63:0] d);
        logic [68:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected_write: got x%0d=%h expected no write", a, d);
        end else begin
            e = exp_q.pop_front();
            chk("wb_rd", 64'(a), 64'(e[68:64]));
            chk("wb_data", d, e[63:0]);
        end
        wcyc[a] = cyc + 1;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.xrf.we0 && dut.xrf.wa0 != 5'd0) mon_write(dut.xrf.wa0, dut.xrf.wd0);
            if (dut.xrf.we1 && dut.xrf.wa1 != 5'd0) mon_write(dut.xrf.wa1, dut.xrf.wd1);
        end
    end

    task automatic wait_ren();
        int t;
        t = 0;
        while (!ren && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("ren_wait", 64'(ren), 64'd1);
    endtask

    task automatic feed(input logic [63:0] b, input int lat, output int n);
        wait_ren();
        repeat (lat) @(negedge clk);
        chk("raddr", 64'(raddr), 64'(pc_m));
        ivalid = 1'b1;
        idata  = b;
        @(posedge clk);
        #1;
        n      = cyc;
        ivalid = 1'b0;
        idata  = {$urandom, $urandom};
        model_exec(b[31:0]);
        model_exec(b[63:32]);
        pc_m = pc_m + 39'd8;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        chk("drain", 64'(exp_q.size()), 64'd0);
    endtask

    function automatic logic [31:0] rand_ins();
        logic [4:0] rd, rs1, rs2;
        logic [2:0] f3;
        int         k;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        f3  = 3'($urandom_range(0, 7));
        k   = $urandom_range(0, 9);
        if (k < 4) begin
            if (f3 == 3'd1) return enc_i(f3, rd, rs1, {6'h00, 6'($urandom_range(0, 63))});
            if (f3 == 3'd5) return enc_i(f3, rd, rs1, {($urandom_range(0, 1) != 0) ? 6'h10 : 6'h00,
                                                       6'($urandom_range(0, 63))});
            return enc_i(f3, rd, rs1, 12'($urandom));
        end
        if (k < 8) return enc_r(((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) != 0) ? 7'h20 : 7'h00,
                                f3, rd, rs1, rs2);
        if (k == 8) return {20'($urandom), rd, 7'h37};
        return {25'($urandom), 7'h0b};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int n;
        logic [63:0] b;
        rst_n  = 1'b0;
        ivalid = 1'b0;
        idata  = '0;
        model_reset();
        for (int i = 0; i < 32; i++) wcyc[i] = 0;
        repeat (3) @(negedge clk);
        chk("rst_ren", 64'(ren), 64'd0);
        chk("rst_raddr", 64'(raddr), 64'(RST_A));
        rst_n = 1'b1;
        #1;
        chk("init_ren", 64'(ren), 64'd0);
        wait_ren();
        chk("fetch_raddr", 64'(raddr), 64'(RST_A));
        repeat (3) @(negedge clk);
        chk("raddr_held", 64'(raddr), 64'(RST_A));
        chk("ren_held", 64'(ren), 64'd1);

        // paired issue: ori (logic lane) with addi (arith lane)
        feed(64'h08206113_07800093, 0, n);
        chk("raddr_next", 64'(raddr), 64'(RST_A + 39'd8));
        repeat (2) @(posedge clk);
        #1;
        chk("x1_early", dut.xrf.file[1], 64'd0);
        @(posedge clk);
        #1;
        chk("x1_n3", dut.xrf.file[1], 64'd120);
        chk("x2_n3", dut.xrf.file[2], 64'd130);
        drain();

        // same lane: second addi one cycle later
        feed(64'h08200113_07800093, 1, n);
        drain();
        chk("same_lane_x1_cyc", 64'(wcyc[1]), 64'(n + 3));
        chk("same_lane_x2_cyc", 64'(wcyc[2]), 64'(n + 4));

        // RAW inside a bundle
        feed(64'h00708193_00500093, 0, n);
        drain();
        chk("raw_x1_cyc", 64'(wcyc[1]), 64'(n + 3));
        chk("raw_x3_stalled", 64'(wcyc[3] > n + 3 && wcyc[3] <= n + 5), 64'd1);
        chk("raw_x3", dut.xrf.file[3], 64'd12);

        // write to x0 is dropped
        feed(64'hfff00013_07800093, 0, n);
        drain();
        chk("x0_zero", dut.xrf.file[0], 64'd0);
        chk("x1_120", dut.xrf.file[1], 64'd120);

        // negative operands
        feed({enc_i(3'd0, 5'd5, 5'd0, 12'd3), enc_i(3'd0, 5'd4, 5'd0, 12'hffb)}, 0, n);
        feed({enc_r(7'h20, 3'd5, 5'd7, 5'd4, 5'd5), enc_r(7'h20, 3'd0, 5'd6, 5'd5, 5'd4)}, 2, n);
        feed({enc_r(7'h00, 3'd3, 5'd9, 5'd4, 5'd5), enc_r(7'h00, 3'd2, 5'd8, 5'd4, 5'd5)}, 0, n);
        feed({enc_i(3'd5, 5'd11, 5'd4, 12'h401), enc_i(3'd3, 5'd10, 5'd5, 12'hffb)}, 1, n);
        drain();
        chk("sub", dut.xrf.file[6], 64'd8);
        chk("sra", dut.xrf.file[7], 64'hffff_ffff_ffff_ffff);
        chk("slt", dut.xrf.file[8], 64'd1);
        chk("sltu", dut.xrf.file[9], 64'd0);
        chk("sltiu", dut.xrf.file[10], 64'd1);
        chk("srai", dut.xrf.file[11], 64'hffff_ffff_ffff_fffd);

        // pair writing the same rd: younger slot wins
        feed({enc_i(3'd4, 5'd12, 5'd0, 12'd7), enc_i(3'd0, 5'd12, 5'd0, 12'd3)}, 0, n);
        drain();
        chk("waw_pair", dut.xrf.file[12], 64'd7);
        chk("waw_pair_cyc", 64'(wcyc[12]), 64'(n + 3));

        // reset while an instruction is in Execute
        feed({enc_i(3'd0, 5'd6, 5'd0, 12'd66), enc_i(3'd0, 5'd5, 5'd0, 12'd55)}, 0, n);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n  = 1'b0;
        model_reset();
        ivalid = 1'b1;
        idata  = {enc_i(3'd0, 5'd7, 5'd0, 12'd1), enc_i(3'd0, 5'd7, 5'd0, 12'd1)};
        #1;
        for (int i = 0; i < 32; i++) chk("rst_reg", dut.xrf.file[i], 64'd0);
        chk("rst_mid_ren", 64'(ren), 64'd0);
        chk("rst_mid_raddr", 64'(raddr), 64'(RST_A));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        wait_ren();
        chk("restart_raddr", 64'(raddr), 64'(RST_A));
        repeat (5) @(negedge clk);
        chk("stale_resp_ignored", dut.xrf.file[7], 64'd0);
        chk("no_exec_write", dut.xrf.file[5], 64'd0);

        // randomized streams with hazards and random fetch latency
        for (int k = 0; k < 80; k++) begin
            b = {rand_ins(), rand_ins()};
            feed(b, $urandom_range(0, 2), n);
        end
        drain();
        for (int i = 0; i < 32; i++) chk("final_reg", dut.xrf.file[i], xm[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
